// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared constants, clear-FSM state type and port-slicing helper for regfile_mp
// Ports: none (package).
package regfile_mp_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NUM_RD = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } clr_state_t;

   // LSB position of lane 'port' in a packed bus of 'width'-bit lanes.
   function automatic int slice_lsb(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read port: zero check, bypass priority mux, busy masking
// Ports:
//   ra        read address
//   byp_en    bypass allowed this cycle (low during clear sweep or reset)
//   we0..wd1  write lanes 0/1 as seen by the register file
//   arr_data  array contents at ra
//   sb_bit    scoreboard bit at ra
//   rd        read data
//   rbusy     pending-write flag, masked on a bypass hit
module regfile_rd_port
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int BYPASS = 1
)
(
   input  logic [ADDR_W-1:0] ra,
   input  logic              byp_en,
   input  logic              we0,
   input  logic [ADDR_W-1:0] wa0,
   input  logic [DATA_W-1:0] wd0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] wa1,
   input  logic [DATA_W-1:0] wd1,
   input  logic [DATA_W-1:0] arr_data,
   input  logic              sb_bit,
   output logic [DATA_W-1:0] rd,
   output logic              rbusy
);

   logic byp_ok;
   logic hit0;
   logic hit1;

   assign byp_ok = (BYPASS != 0) && byp_en;
   assign hit1   = byp_ok && we1 && (wa1 == ra);
   assign hit0   = byp_ok && we0 && (wa0 == ra);

   // Lane 1 is checked first so it wins a same-address collision, matching the write order.
   // A bypassed value is the producer's result, so the register is no longer pending.
   always_comb begin
      rd    = arr_data;
      rbusy = sb_bit;
      if (ra == '0) begin
         rd    = '0;
         rbusy = 1'b0;
      end else if (hit1) begin
         rd    = wd1;
         rbusy = 1'b0;
      end else if (hit0) begin
         rd    = wd0;
         rbusy = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read dual-write register file with bypass, scoreboard and clear sweep
// Optional feature macro: REGFILE_MP_DEBUG_PORT_EN (adds DBG_ADDR / DBG_DATA / DBG_SB).
// Ports:
//   CLK, RESET       clock, asynchronous active-high reset
//   RA, RD, RBUSY    packed read addresses, read data, pending-write flags (NUM_RD lanes)
//   WE0/WA0/WD0      write lane 0
//   WE1/WA1/WD1      write lane 1 (wins over lane 0 on same address)
//   SB_SET, SB_ADDR  mark register as pending-write
//   CLR_REQ          start clear sweep
//   CLR_BUSY         sweep in progress
//   DBG_ADDR/DBG_DATA/DBG_SB  unbypassed array view and full scoreboard (macro only)
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = DEF_NUM_RD,
   parameter int BYPASS = 1
)
(
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [NUM_RD*ADDR_W-1:0] RA,
   output logic [NUM_RD*DATA_W-1:0] RD,
   output logic [NUM_RD-1:0]        RBUSY,
   input  logic                     WE0,
   input  logic [ADDR_W-1:0]        WA0,
   input  logic [DATA_W-1:0]        WD0,
   input  logic                     WE1,
   input  logic [ADDR_W-1:0]        WA1,
   input  logic [DATA_W-1:0]        WD1,
   input  logic                     SB_SET,
   input  logic [ADDR_W-1:0]        SB_ADDR,
   input  logic                     CLR_REQ,
`ifdef REGFILE_MP_DEBUG_PORT_EN
   input  logic [ADDR_W-1:0]        DBG_ADDR,
   output logic [DATA_W-1:0]        DBG_DATA,
   output logic [(1<<ADDR_W)-1:0]   DBG_SB,
`endif
   output logic                     CLR_BUSY
);

   localparam int                DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

   clr_state_t        state;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  sb;
   logic              idle;
   logic              byp_en;

   assign idle   = (state == IDLE);
   // Gating with RESET keeps every read at zero while reset is held.
   assign byp_en = idle && !RESET;

   // Clear sequencer: walks ptr from 1 to DEPTH-1, entry 0 is never written anyway.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state    <= IDLE;
         ptr      <= '0;
         CLR_BUSY <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (CLR_REQ) begin
                  state    <= SWEEP;
                  ptr      <= ADDR_W'(1);
                  CLR_BUSY <= 1'b1;
               end
            end
            SWEEP: begin
               if (ptr == LAST) begin
                  state    <= IDLE;
                  CLR_BUSY <= 1'b0;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               CLR_BUSY <= 1'b0;
            end
         endcase
      end
   end

   // Array and scoreboard. Later non-blocking assignments win, which gives lane 1 priority
   // on data and lets SB_SET override a same-cycle retire clear.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         sb <= '0;
      end else if (!idle) begin
         mem[ptr] <= '0;
         sb[ptr]  <= 1'b0;
      end else begin
         if (WE0 && (WA0 != '0)) begin
            mem[WA0] <= WD0;
            sb[WA0]  <= 1'b0;
         end
         if (WE1 && (WA1 != '0)) begin
            mem[WA1] <= WD1;
            sb[WA1]  <= 1'b0;
         end
         if (SB_SET && (SB_ADDR != '0)) begin
            sb[SB_ADDR] <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      localparam int A_LSB = slice_lsb(i, ADDR_W);
      localparam int D_LSB = slice_lsb(i, DATA_W);

      logic [ADDR_W-1:0] ra;
      assign ra = RA[A_LSB +: ADDR_W];

      regfile_rd_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .BYPASS (BYPASS)
      ) u_port (
         .ra       (ra),
         .byp_en   (byp_en),
         .we0      (WE0),
         .wa0      (WA0),
         .wd0      (WD0),
         .we1      (WE1),
         .wa1      (WA1),
         .wd1      (WD1),
         .arr_data (mem[ra]),
         .sb_bit   (sb[ra]),
         .rd       (RD[D_LSB +: DATA_W]),
         .rbusy    (RBUSY[i])
      );
   end

`ifdef REGFILE_MP_DEBUG_PORT_EN
   assign DBG_DATA = mem[DBG_ADDR];
   assign DBG_SB   = sb;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (BYPASS=1 and BYPASS=0 instances)
module tb_regfile_mp;

   logic        CLK;
   logic        RESET;
   logic [9:0]  RA;
   logic [63:0] RD, RD_NB;
   logic [1:0]  RBUSY, RBUSY_NB;
   logic        WE0, WE1, SB_SET, CLR_REQ;
   logic [4:0]  WA0, WA1, SB_ADDR;
   logic [31:0] WD0, WD1;
   logic        CLR_BUSY, CLR_BUSY_NB;
`ifdef REGFILE_MP_DEBUG_PORT_EN
   logic [4:0]  DBG_ADDR;
   logic [31:0] DBG_DATA, DBG_DATA_NB;
   logic [31:0] DBG_SB, DBG_SB_NB;
   assign DBG_ADDR = '0;
`endif

   int checks = 0;
   int errors = 0;

   regfile_mp #(.BYPASS(1)) dut (
      .CLK(CLK), .RESET(RESET), .RA(RA), .RD(RD), .RBUSY(RBUSY),
      .WE0(WE0), .WA0(WA0), .WD0(WD0), .WE1(WE1), .WA1(WA1), .WD1(WD1),
      .SB_SET(SB_SET), .SB_ADDR(SB_ADDR), .CLR_REQ(CLR_REQ),
`ifdef REGFILE_MP_DEBUG_PORT_EN
      .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA), .DBG_SB(DBG_SB),
`endif
      .CLR_BUSY(CLR_BUSY)
   );

   regfile_mp #(.BYPASS(0)) dut_nb (
      .CLK(CLK), .RESET(RESET), .RA(RA), .RD(RD_NB), .RBUSY(RBUSY_NB),
      .WE0(WE0), .WA0(WA0), .WD0(WD0), .WE1(WE1), .WA1(WA1), .WD1(WD1),
      .SB_SET(SB_SET), .SB_ADDR(SB_ADDR), .CLR_REQ(CLR_REQ),
`ifdef REGFILE_MP_DEBUG_PORT_EN
      .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA_NB), .DBG_SB(DBG_SB_NB),
`endif
      .CLR_BUSY(CLR_BUSY_NB)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: plain arrays, sweep tracked as "next address to clear".
   logic [31:0] m_mem [32];
   bit          m_sb  [32];
   bit          m_sweep;
   int          m_next;

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m_mem[i] = '0;
         m_sb[i]  = 1'b0;
      end
      m_sweep = 1'b0;
      m_next  = 0;
   endtask

   function automatic logic [31:0] exp_rd(input int a, input bit byp);
      if (RESET || a == 0) return '0;
      if (byp && !m_sweep && WE1 && int'(WA1) == a) return WD1;
      if (byp && !m_sweep && WE0 && int'(WA0) == a) return WD0;
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input int a, input bit byp);
      if (RESET || a == 0) return 1'b0;
      if (byp && !m_sweep && ((WE1 && int'(WA1) == a) || (WE0 && int'(WA0) == a))) return 1'b0;
      return m_sb[a];
   endfunction

   task automatic model_edge();
      if (RESET) begin
         model_clear();
      end else if (m_sweep) begin
         m_mem[m_next] = '0;
         m_sb[m_next]  = 1'b0;
         if (m_next == 31) m_sweep = 1'b0;
         else m_next++;
      end else begin
         if (WE0 && WA0 != 0) begin m_mem[WA0] = WD0; m_sb[WA0] = 1'b0; end
         if (WE1 && WA1 != 0) begin m_mem[WA1] = WD1; m_sb[WA1] = 1'b0; end
         if (SB_SET && SB_ADDR != 0) m_sb[SB_ADDR] = 1'b1;
         if (CLR_REQ) begin m_sweep = 1'b1; m_next = 1; end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_check();
      for (int p = 0; p < 2; p++) begin
         int a;
         a = int'(RA[p*5 +: 5]);
         chk($sformatf("rd%0d_byp a=%0d", p, a),    RD[p*32 +: 32],    exp_rd(a, 1'b1));
         chk($sformatf("busy%0d_byp a=%0d", p, a),  32'(RBUSY[p]),     32'(exp_busy(a, 1'b1)));
         chk($sformatf("rd%0d_nobyp a=%0d", p, a),  RD_NB[p*32 +: 32], exp_rd(a, 1'b0));
         chk($sformatf("busy%0d_nobyp a=%0d", p, a), 32'(RBUSY_NB[p]),  32'(exp_busy(a, 1'b0)));
      end
      chk("clr_busy_byp",   32'(CLR_BUSY),    32'(m_sweep));
      chk("clr_busy_nobyp", 32'(CLR_BUSY_NB), 32'(m_sweep));
   endtask

   // Inputs are set at the falling edge; outputs checked 1 time unit later, then the model steps.
   task automatic cycle();
      if (RESET) model_clear();
      #1;
      model_check();
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
   endtask

   task automatic idle_in();
      WE0 = 0; WA0 = 0; WD0 = 0; WE1 = 0; WA1 = 0; WD1 = 0;
      SB_SET = 0; SB_ADDR = 0; CLR_REQ = 0;
   endtask

   typedef struct {
      logic        we0; logic [4:0] wa0; logic [31:0] wd0;
      logic        we1; logic [4:0] wa1; logic [31:0] wd1;
      logic        sb_set; logic [4:0] sb_addr;
      logic [4:0]  ra0; logic [4:0] ra1;
      logic [31:0] rd0; logic bz0; logic [31:0] rd1; logic bz1;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int count;
      tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0};
      tbl[1]  = '{0, 0, 0,            0, 0, 0,        0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0};
      tbl[2]  = '{1, 7, 32'h11,       1, 7, 32'h22,   0, 0, 7, 0, 32'h22, 0, 0, 0};
      tbl[3]  = '{0, 0, 0,            0, 0, 0,        0, 0, 7, 5, 32'h22, 0, 32'hDEADBEEF, 0};
      tbl[4]  = '{1, 0, 32'hFF,       0, 0, 0,        0, 0, 0, 7, 0, 0, 32'h22, 0};
      tbl[5]  = '{0, 0, 0,            0, 0, 0,        1, 3, 3, 0, 0, 0, 0, 0};
      tbl[6]  = '{0, 0, 0,            0, 0, 0,        0, 0, 3, 0, 0, 1, 0, 0};
      tbl[7]  = '{1, 3, 32'h33,       0, 0, 0,        1, 3, 3, 0, 32'h33, 0, 0, 0};
      tbl[8]  = '{0, 0, 0,            0, 0, 0,        0, 0, 3, 0, 32'h33, 1, 0, 0};
      tbl[9]  = '{0, 0, 0,            1, 3, 32'h44,   0, 0, 3, 5, 32'h44, 0, 32'hDEADBEEF, 0};
      tbl[10] = '{0, 0, 0,            0, 0, 0,        0, 0, 3, 7, 32'h44, 0, 32'h22, 0};
      tbl[11] = '{0, 0, 0,            0, 0, 0,        1, 0, 0, 0, 0, 0, 0, 0};
      tbl[12] = '{0, 0, 0,            0, 0, 0,        0, 0, 0, 3, 0, 0, 32'h44, 0};

      RESET = 1; RA = '0; idle_in(); model_clear();
      @(negedge CLK);
      cycle();
      cycle();
      RESET = 0;
      for (int a = 0; a < 32; a++) begin
         RA = {5'(31 - a), 5'(a)};
         cycle();
      end

      // Directed vectors
      for (int i = 0; i < 13; i++) begin
         WE0 = tbl[i].we0; WA0 = tbl[i].wa0; WD0 = tbl[i].wd0;
         WE1 = tbl[i].we1; WA1 = tbl[i].wa1; WD1 = tbl[i].wd1;
         SB_SET = tbl[i].sb_set; SB_ADDR = tbl[i].sb_addr; CLR_REQ = 0;
         RA = {tbl[i].ra1, tbl[i].ra0};
         #1;
         chk($sformatf("vec%0d rd0", i),   RD[31:0],        tbl[i].rd0);
         chk($sformatf("vec%0d busy0", i), 32'(RBUSY[0]),   32'(tbl[i].bz0));
         chk($sformatf("vec%0d rd1", i),   RD[63:32],       tbl[i].rd1);
         chk($sformatf("vec%0d busy1", i), 32'(RBUSY[1]),   32'(tbl[i].bz1));
         if (i == 0) chk("vec0 nobyp rd0", RD_NB[31:0], 32'h0);
         if (i == 1) chk("vec1 nobyp rd0", RD_NB[31:0], 32'hDEADBEEF);
         cycle();
      end
      idle_in();

      // Fill, then clear sweep with ignored writes/requests mid-sweep
      for (int a = 1; a < 32; a++) begin
         WE0 = 1; WA0 = 5'(a); WD0 = 32'hA5A5A5A5; SB_SET = 1; SB_ADDR = 5'(a);
         RA = {5'(a), 5'(a - 1)};
         cycle();
      end
      idle_in();
      CLR_REQ = 1;
      cycle();
      count = 0;
      RA = {5'd9, 5'd9};
      for (int g = 0; g < 100; g++) begin
         WE0 = (count == 4); WA0 = 9; WD0 = 32'h1234;
         SB_SET = (count == 4); SB_ADDR = 9;
         CLR_REQ = (count == 6);
         #1;
         if (!CLR_BUSY) break;
         count++;
         cycle();
      end
      idle_in();
      chk("sweep_len", 32'(count), 32'd31);
      for (int a = 0; a < 32; a++) begin
         RA = {5'(a), 5'(a)};
         #1;
         chk($sformatf("post_sweep rd a=%0d", a), RD[31:0], 32'h0);
         cycle();
      end

      // Reset in the middle of a sweep
      WE0 = 1; WA0 = 6; WD0 = 32'h66; SB_SET = 1; SB_ADDR = 4;
      cycle();
      idle_in();
      SB_SET = 1; SB_ADDR = 6;
      cycle();
      idle_in();
      CLR_REQ = 1;
      RA = {5'd6, 5'd4};
      cycle();
      CLR_REQ = 0;
      repeat (10) cycle();
      RESET = 1;
      #1;
      chk("rst_abort_clr_busy", 32'(CLR_BUSY), 32'd0);
      chk("rst_abort_rd6", RD[63:32], 32'h0);
      cycle();
      RESET = 0;
      for (int a = 0; a < 32; a++) begin
         RA = {5'(31 - a), 5'(a)};
         cycle();
      end
      WE0 = 1; WA0 = 1; WD0 = 32'h111; WE1 = 1; WA1 = 2; WD1 = 32'h222;
      cycle();
      idle_in();
      CLR_REQ = 1;
      RA = {5'd2, 5'd1};
      cycle();
      CLR_REQ = 0;
      cycle();
      #1;
      chk("restart_ptr1_r1", RD[31:0], 32'h0);
      chk("restart_ptr1_r2", RD[63:32], 32'h222);
      count = 0;
      for (int g = 0; g < 100; g++) begin
         #1;
         if (!CLR_BUSY) break;
         count++;
         cycle();
      end
      chk("restart_sweep_rest", 32'(count), 32'd30);

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         RESET   = ($urandom_range(0, 249) == 0);
         WE0     = $urandom_range(0, 1);
         WA0     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         WD0     = $urandom;
         WE1     = $urandom_range(0, 1);
         WA1     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         WD1     = $urandom;
         SB_SET  = $urandom_range(0, 1);
         SB_ADDR = 5'($urandom_range(0, 7));
         CLR_REQ = ($urandom_range(0, 59) == 0);
         RA      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         cycle();
      end
      RESET = 0;
      idle_in();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
